// File: rtl/lsu_mem_port.sv
// Load/store unit driving a word-addressed memory port. Sub-word stores use
// read-modify-write; loads return lane-extracted, extended data.
module lsu_mem_port (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] mem_addr,
   output logic        mem_ren,
   input  logic [31:0] mem_rdata,
   output logic        mem_wen,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_wdata
);

   typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;
   state_t state, state_nxt;

   logic        we_q, uns_q, err_q;
   logic [1:0]  size_q;
   logic [31:0] addr_q, wdata_q, merged_q, rdata_q;

   logic        req_err, is_sw;
   logic [3:0]  lane_strb;
   logic [31:0] lane_mask, rd_shift, wd_shift, load_val;

   assign req_err = (req_size == 2'b11) ||
                    (req_size == 2'b01 && req_addr[0]) ||
                    (req_size == 2'b10 && req_addr[1:0] != 2'b00);
   assign is_sw   = (size_q == 2'b10);

   // Lane data is moved by the byte offset; for halves addr[0] is known 0.
   assign rd_shift = mem_rdata >> {addr_q[1:0], 3'b000};
   assign wd_shift = wdata_q << {addr_q[1:0], 3'b000};

   always_comb begin
      lane_strb = 4'b0000;
      case (size_q)
         2'b00:   lane_strb = 4'b0001 << addr_q[1:0];
         2'b01:   lane_strb = addr_q[1] ? 4'b1100 : 4'b0011;
         default: lane_strb = 4'b1111;
      endcase
   end

   assign lane_mask = {{8{lane_strb[3]}}, {8{lane_strb[2]}},
                       {8{lane_strb[1]}}, {8{lane_strb[0]}}};

   always_comb begin
      load_val = mem_rdata;
      case (size_q)
         2'b00:   load_val = {{24{~uns_q & rd_shift[7]}}, rd_shift[7:0]};
         2'b01:   load_val = {{16{~uns_q & rd_shift[15]}}, rd_shift[15:0]};
         default: load_val = mem_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req_valid) state_nxt = req_err ? RESP : ACCESS;
         ACCESS:  state_nxt = (!we_q || is_sw) ? RESP : WRITE;
         WRITE:   state_nxt = RESP;
         RESP:    if (resp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q     <= 1'b0;
         uns_q    <= 1'b0;
         size_q   <= 2'b00;
         addr_q   <= 32'h0;
         wdata_q  <= 32'h0;
         merged_q <= 32'h0;
         rdata_q  <= 32'h0;
         err_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: if (req_valid) begin
               we_q    <= req_we;
               uns_q   <= req_unsigned;
               size_q  <= req_size;
               addr_q  <= req_addr;
               wdata_q <= req_wdata;
               err_q   <= req_err;
               rdata_q <= 32'h0;
            end
            ACCESS: begin
               if (!we_q)       rdata_q  <= load_val;
               else if (!is_sw) merged_q <= (mem_rdata & ~lane_mask) | (wd_shift & lane_mask);
            end
            RESP: if (resp_ready) begin
               rdata_q <= 32'h0;
               err_q   <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      req_ready  = (state == IDLE);
      resp_valid = (state == RESP);
      resp_rdata = rdata_q;
      resp_err   = err_q;
      mem_addr   = {addr_q[31:2], 2'b00};
      mem_ren    = 1'b0;
      mem_wen    = 1'b0;
      mem_wstrb  = 4'b0000;
      mem_wdata  = 32'h0;
      case (state)
         ACCESS: begin
            if (we_q && is_sw) begin
               mem_wen   = 1'b1;
               mem_wstrb = 4'b1111;
               mem_wdata = wdata_q;
            end else begin
               mem_ren   = 1'b1;
            end
         end
         WRITE: begin
            mem_wen   = 1'b1;
            mem_wstrb = lane_strb;
            mem_wdata = merged_q;
         end
         default: ;
      endcase
   end

endmodule
